led_frame_gen: RTL and testbench
================================

# led_frame_gen

Scans one 10x10 game board memory cell by cell and turns each 2-bit cell code into a 32-bit APA102-style LED word. It sits directly downstream of the game board memories and directly upstream of the SPI serializer. It sources the board read address and enable, consumes the registered read data, and hands complete LED words to the serializer through a valid/ready handshake. A full frame is a start word, one word per cell, then end words.

## Interface
Parameters:
- ROWS, 10, board rows scanned (max 16)
- COLS, 10, board columns scanned (max 16)
- BRIGHT, 5'd8, global brightness field placed in every pixel word
- END_WORDS, 2, number of 32'hFFFF_FFFF end words after the last pixel

Ports:
- ph2  in  1  clock; the block uses a single clock
- reset  in  1  reset, synchronous and active-low (0 = reset, sampled on ph2 rising edge)
- start  in  1  frame request; sampled only in IDLE
- board_sel  in  1  selects player board 0/1; captured at accepted start
- sel_q  out  1  captured board select that drives the external read-data mux
- rd_en  out  1  read enable to gb_mem
- row  out  4  board row address
- col  out  4  board column address
- rd_data  in  2  gb_mem read data, valid the cycle after rd_en
- word  out  32  LED word to the serializer
- word_valid  out  1  word is valid
- word_ready  in  1  serializer accepts word; transfer on valid&&ready at the ph2 edge
- busy  out  1  high in every state except IDLE
- frame_done  out  1  one-cycle pulse after the final end word is accepted

## Operation
- Reset values: word=0, word_valid=0, rd_en=0, row=0, col=0, busy=0, frame_done=0, sel_q=0, state=IDLE.
- FSM states: IDLE, SOF, READ, LATCH, SEND, EOF, DONE.
- IDLE: if start=1, capture board_sel into sel_q, zero the row and column counters, then go to SOF. Otherwise stay in IDLE.
- SOF: word=32'h0000_0000 with word_valid=1. Hold until accepted, then go to READ.
- READ: rd_en=1, row/col driven from the counters. Go to LATCH.
- LATCH: rd_en=0. Register word={3'b111, BRIGHT, B, G, R} from rd_data, then go to SEND. The colour map is:
  - 00 gives 00/00/00 (off)
  - 01 gives B=FF (miss)
  - 10 gives R=FF (hit)
  - 11 gives G=FF (ship)
- SEND: word_valid=1. On acceptance, advance the column counter.
  - If the row is not finished, go to READ.
  - If the row wraps and more rows remain, increment row and go to READ.
  - After cell (ROWS-1, last column), go to EOF.
- EOF: word=32'hFFFF_FFFF, word_valid=1. Repeat END_WORDS times, counting each accepted transfer, then go to DONE.
- DONE: frame_done=1 for one cycle, then go to IDLE.
- Words per default frame: 1 + 100 + 2 = 103.
- word and word_valid stay stable while word_valid=1 and word_ready=0. word_valid is never dropped before acceptance, except by reset.
- start or a board_sel change while busy=1 is ignored; sel_q holds for the whole frame.
- Reset mid-frame returns to reset values on the next edge. word_valid may drop without acceptance, and the serializer discards the truncated frame. No frame_done pulse is issued.
- Row and column counters are 4 bits. The comparisons use ROWS-1 and COLS-1, and addresses never exceed those bounds.

## Timing
- Memory read latency is 1 cycle: rd_en in READ at edge N, rd_data sampled in LATCH at edge N+1.
- Start is accepted at edge T, and SOF word_valid is high in cycle T+1.
- With word_ready tied high:
  - SOF takes 1 cycle.
  - Each pixel takes 3 cycles (READ, LATCH, SEND).
  - Each end word takes 1 cycle.
  - DONE takes 1 cycle.
  - Default frame: 1 + 300 + 2 + 1 = 304 cycles from SOF to the end of the frame_done pulse. busy falls the cycle after frame_done.
- Each cycle of word_ready=0 in SOF, SEND or EOF adds exactly one cycle.
- start asserted in the same cycle as frame_done is ignored, because the block is not yet in IDLE.

## Configuration
- LED_SERPENTINE_EN defined: odd rows scan col = COLS-1 down to 0, matching the zig-zag wiring of the LED strip. Even rows scan 0 up to COLS-1.
- LED_SERPENTINE_EN undefined: every row scans col 0 up to COLS-1.
- Nothing else changes between the two builds: word count, timing and colour map are identical.

## Test plan
- Reset: hold reset=0 for 3 cycles with start=1. Required: all outputs at reset values; after release, a frame starts on the next edge.
- All-zero board with word_ready=1:
  - Exactly 103 transfers.
  - Word 0 = 32'h0000_0000, words 1-100 = 32'hE800_0000, words 101-102 = 32'hFFFF_FFFF.
  - frame_done pulses once, 304 cycles after SOF.
- Colour map: cell (0,0)=01, (0,1)=10, (0,2)=11, rest 00. Required: words 1-3 = 32'hE8FF_0000, 32'hE800_00FF, 32'hE800_FF00.
- Backpressure: random word_ready at 30% duty. Required: word stable while stalled, the same 103 words in the same order, no dropped or duplicated transfer.
- Ordering with LED_SERPENTINE_EN: each cell holds a unique code pattern. Required: the row-1 read addresses go col 9→0; without the macro they go col 0→9.
- Mid-frame events:
  - start and a board_sel toggle at word 50: ignored, sel_q unchanged.
  - reset=0 at word 60: word_valid=0 and busy=0 after one edge, no frame_done pulse.
  - Next start: a clean frame begins with SOF.

Source files
------------

// File: rtl/led_frame_gen_if.sv
// ============================================================================
//  Module      : led_frame_gen_if
//  Description : Board-memory read port and serializer word handshake used by
//                led_frame_gen. The master modport is the frame generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface led_frame_gen_if;
    logic        sel_q;
    logic        rd_en;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [1:0]  rd_data;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;

    modport master (
        output sel_q,
        output rd_en,
        output row,
        output col,
        input  rd_data,
        output word,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  sel_q,
        input  rd_en,
        input  row,
        input  col,
        output rd_data,
        input  word,
        input  word_valid,
        output word_ready
    );
endinterface

`default_nettype wire

// File: rtl/led_frame_gen.sv
// ============================================================================
//  Module      : led_frame_gen
//  Description : Scans a ROWSxCOLS game board and emits an APA102-style frame
//                (start word, one pixel word per cell, END_WORDS end words).
//                Optional macro LED_SERPENTINE_EN: odd rows scan right-to-left.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_frame_gen #(
    parameter int unsigned ROWS      = 10,
    parameter int unsigned COLS      = 10,
    parameter logic [4:0]  BRIGHT    = 5'd8,
    parameter int unsigned END_WORDS = 2
) (
    input  wire            ph2,
    input  wire            reset,
    input  wire            start,
    input  wire            board_sel,
    output logic           busy,
    output logic           frame_done,
    led_frame_gen_if.master bus
);

    localparam logic [3:0]  ROW_LAST = 4'(ROWS - 1);
    localparam logic [3:0]  COL_LAST = 4'(COLS - 1);
    localparam logic [7:0]  END_LAST = 8'(END_WORDS - 1);
    localparam logic [31:0] SOF_WORD = 32'h0000_0000;
    localparam logic [31:0] EOF_WORD = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SOF   = 3'd1,
        S_READ  = 3'd2,
        S_LATCH = 3'd3,
        S_SEND  = 3'd4,
        S_EOF   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t      state_q;
    logic        sel_q;
    logic        rd_en_q;
    logic [3:0]  row_q;
    logic [3:0]  col_q;
    logic [31:0] word_q;
    logic        word_valid_q;
    logic        busy_q;
    logic        frame_done_q;
    logic [7:0]  end_cnt_q;

    logic [3:0]  row_d;
    logic [3:0]  col_d;
    logic        row_end_d;
    logic        last_cell_d;
    logic [31:0] pixel_d;

    // Scan-order stepping: which column ends a row, and where the next row starts.
    always_comb begin
        row_d = row_q;
        col_d = col_q;
`ifdef LED_SERPENTINE_EN
        row_end_d = row_q[0] ? (col_q == 4'd0) : (col_q == COL_LAST);
        if (row_end_d) begin
            row_d = row_q + 4'd1;
            col_d = row_q[0] ? 4'd0 : COL_LAST;
        end else begin
            col_d = row_q[0] ? (col_q - 4'd1) : (col_q + 4'd1);
        end
`else
        row_end_d = (col_q == COL_LAST);
        if (row_end_d) begin
            row_d = row_q + 4'd1;
            col_d = 4'd0;
        end else begin
            col_d = col_q + 4'd1;
        end
`endif
        last_cell_d = row_end_d && (row_q == ROW_LAST);
    end

    always_comb begin
        logic [7:0] b, g, r;
        b = 8'h00;
        g = 8'h00;
        r = 8'h00;
        case (bus.rd_data)
            2'b01:   b = 8'hFF;
            2'b10:   r = 8'hFF;
            2'b11:   g = 8'hFF;
            default: ;
        endcase
        pixel_d = {3'b111, BRIGHT, b, g, r};
    end

    always_ff @(posedge ph2) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            sel_q        <= 1'b0;
            rd_en_q      <= 1'b0;
            row_q        <= 4'd0;
            col_q        <= 4'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            end_cnt_q    <= 8'd0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        sel_q        <= board_sel;
                        row_q        <= 4'd0;
                        col_q        <= 4'd0;
                        word_q       <= SOF_WORD;
                        word_valid_q <= 1'b1;
                        busy_q       <= 1'b1;
                        state_q      <= S_SOF;
                    end
                end
                S_SOF: begin
                    if (bus.word_ready) begin
                        word_valid_q <= 1'b0;
                        rd_en_q      <= 1'b1;
                        state_q      <= S_READ;
                    end
                end
                S_READ: begin
                    rd_en_q <= 1'b0;
                    state_q <= S_LATCH;
                end
                S_LATCH: begin
                    word_q       <= pixel_d;
                    word_valid_q <= 1'b1;
                    state_q      <= S_SEND;
                end
                S_SEND: begin
                    if (bus.word_ready) begin
                        if (last_cell_d) begin
                            word_q    <= EOF_WORD;
                            end_cnt_q <= 8'd0;
                            state_q   <= S_EOF;
                        end else begin
                            row_q        <= row_d;
                            col_q        <= col_d;
                            word_valid_q <= 1'b0;
                            rd_en_q      <= 1'b1;
                            state_q      <= S_READ;
                        end
                    end
                end
                S_EOF: begin
                    if (bus.word_ready) begin
                        if (end_cnt_q == END_LAST) begin
                            word_valid_q <= 1'b0;
                            frame_done_q <= 1'b1;
                            state_q      <= S_DONE;
                        end else begin
                            end_cnt_q <= end_cnt_q + 8'd1;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.sel_q      = sel_q;
    assign bus.rd_en      = rd_en_q;
    assign bus.row        = row_q;
    assign bus.col        = col_q;
    assign bus.word       = word_q;
    assign bus.word_valid = word_valid_q;
    assign busy           = busy_q;
    assign frame_done     = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_led_frame_gen.sv
// ============================================================================
//  Module      : tb_led_frame_gen
//  Description : Self-checking bench for led_frame_gen with a board-memory model
//                and a frame-level reference built from the board contents.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_frame_gen;

    localparam int ROWS   = 10;
    localparam int COLS   = 10;
    localparam int NCELL  = ROWS * COLS;
    localparam int NWORDS = 1 + NCELL + 2;
`ifdef LED_SERPENTINE_EN
    localparam bit SERP = 1'b1;
`else
    localparam bit SERP = 1'b0;
`endif

    logic ph2 = 1'b0;
    always #5 ph2 = ~ph2;

    logic reset;
    logic start;
    logic board_sel;
    logic busy;
    logic frame_done;

    led_frame_gen_if bus ();

    led_frame_gen #(
        .ROWS      (ROWS),
        .COLS      (COLS),
        .BRIGHT    (5'd8),
        .END_WORDS (2)
    ) dut (
        .ph2        (ph2),
        .reset      (reset),
        .start      (start),
        .board_sel  (board_sel),
        .busy       (busy),
        .frame_done (frame_done),
        .bus        (bus)
    );

    // Board memories with one-cycle registered read behind the select mux.
    logic [1:0] board [2][NCELL];
    always @(posedge ph2) begin
        if (bus.rd_en) begin
            if (int'(bus.row) < ROWS && int'(bus.col) < COLS)
                bus.rd_data <= board[bus.sel_q][int'(bus.row) * COLS + int'(bus.col)];
            else
                bus.rd_data <= 2'b00;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] got_words [$];
    int          got_addr  [$];
    logic [31:0] exp_words [$];
    int          exp_addr  [$];
    int done_pulses, done_cyc, busy_fall, stall_cycles, stall_err, sel_err;
    bit timed_out;

    function automatic logic [31:0] px(input logic [1:0] code);
        logic [7:0] r, g, b;
        r = 8'h00; g = 8'h00; b = 8'h00;
        if (code == 2'd1) b = 8'hFF;
        if (code == 2'd2) r = 8'hFF;
        if (code == 2'd3) g = 8'hFF;
        return {3'b111, 5'd8, b, g, r};
    endfunction

    task automatic fill_board(input int b, input bit rnd);
        for (int i = 0; i < NCELL; i++)
            board[b][i] = rnd ? 2'($urandom_range(3)) : 2'b00;
    endtask

    task automatic build_model(input bit sel);
        int c;
        exp_words.delete();
        exp_addr.delete();
        exp_words.push_back(32'h0000_0000);
        for (int r = 0; r < ROWS; r++) begin
            for (int k = 0; k < COLS; k++) begin
                c = (SERP && (r % 2 == 1)) ? (COLS - 1 - k) : k;
                exp_addr.push_back(r * 16 + c);
                exp_words.push_back(px(board[sel][r * COLS + c]));
            end
        end
        exp_words.push_back(32'hFFFF_FFFF);
        exp_words.push_back(32'hFFFF_FFFF);
    endtask

    function automatic int word_errs(input int n, output int first_bad);
        int e = 0;
        first_bad = -1;
        for (int i = 0; i < n; i++) begin
            if (i >= got_words.size() || got_words[i] !== exp_words[i]) begin
                if (first_bad < 0) first_bad = i;
                e++;
            end
        end
        return e;
    endfunction

    function automatic int addr_errs();
        int e = 0;
        if (got_addr.size() != exp_addr.size()) e++;
        for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
            if (got_addr[i] != exp_addr[i]) e++;
        return e;
    endfunction

    // Runs one frame; records transfers, read addresses, stalls and timing.
    task automatic run_frame(input bit sel, input int pct, input bit start_on_done, input int budget);
        logic [31:0] prev_word;
        bit prev_stall = 1'b0;
        bit saw_done   = 1'b0;
        got_words.delete();
        got_addr.delete();
        done_pulses = 0; done_cyc = -1; busy_fall = -1;
        stall_cycles = 0; stall_err = 0; sel_err = 0; timed_out = 1'b1;
        prev_word = 32'd0;
        @(negedge ph2);
        start = 1'b1; board_sel = sel;
        @(negedge ph2);
        start = 1'b0;
        for (int cyc = 0; cyc < budget; cyc++) begin
            if (saw_done && !busy) begin
                busy_fall = cyc; start = 1'b0; timed_out = 1'b0;
                break;
            end
            bus.word_ready = (int'($urandom_range(99)) < pct);
            board_sel = 1'($urandom_range(1));
            if (bus.sel_q !== sel) sel_err++;
            if (prev_stall && (bus.word_valid !== 1'b1 || bus.word !== prev_word)) stall_err++;
            if (bus.rd_en) got_addr.push_back(int'(bus.row) * 16 + int'(bus.col));
            if (bus.word_valid && bus.word_ready) got_words.push_back(bus.word);
            if (bus.word_valid && !bus.word_ready) stall_cycles++;
            prev_stall = bus.word_valid && !bus.word_ready;
            prev_word  = bus.word;
            if (frame_done) begin
                done_pulses++; done_cyc = cyc; saw_done = 1'b1;
                if (start_on_done) start = 1'b1;
            end
            @(negedge ph2);
        end
        start = 1'b0;
        bus.word_ready = 1'b1;
    endtask

    task automatic test_reset();
        int i;
        reset = 1'b0; start = 1'b1; board_sel = 1'b1; bus.word_ready = 1'b1;
        repeat (3) @(posedge ph2);
        @(negedge ph2);
        n_tests++;
        if (bus.word !== 32'd0 || bus.word_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_word: got %h/%b expected 00000000/0", bus.word, bus.word_valid);
        end
        n_tests++;
        if (busy !== 1'b0 || frame_done !== 1'b0 || bus.sel_q !== 1'b0) begin
            n_fail++; $display("FAIL reset_status: busy=%b done=%b sel_q=%b expected 0/0/0", busy, frame_done, bus.sel_q);
        end
        n_tests++;
        if (bus.rd_en !== 1'b0 || bus.row !== 4'd0 || bus.col !== 4'd0) begin
            n_fail++; $display("FAIL reset_read: rd_en=%b row=%0d col=%0d expected 0/0/0", bus.rd_en, bus.row, bus.col);
        end
        reset = 1'b1;
        @(negedge ph2);
        n_tests++;
        if (busy !== 1'b1 || bus.word_valid !== 1'b1 || bus.word !== 32'd0 || bus.sel_q !== 1'b1) begin
            n_fail++; $display("FAIL reset_release_sof: busy=%b valid=%b word=%h sel_q=%b expected 1/1/00000000/1",
                               busy, bus.word_valid, bus.word, bus.sel_q);
        end
        start = 1'b0;
        for (i = 0; i < 400; i++) begin
            if (!busy) break;
            @(negedge ph2);
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_drain: busy=%b after %0d cycles expected 0", busy, i);
        end
    endtask

    task automatic test_zero_board();
        int fb, ne;
        fill_board(0, 1'b0); fill_board(1, 1'b1);
        build_model(1'b0);
        run_frame(1'b0, 100, 1'b0, 1000);
        n_tests++;
        if (timed_out) begin n_fail++; $display("FAIL zero_timeout: frame did not finish, expected finish"); end
        n_tests++;
        if (got_words.size() != NWORDS) begin
            n_fail++; $display("FAIL zero_count: got %0d transfers expected %0d", got_words.size(), NWORDS);
        end
        ne = word_errs(NWORDS, fb);
        n_tests++;
        if (ne != 0) begin
            n_fail++; $display("FAIL zero_words: %0d bad words, first at %0d expected 0 bad", ne, fb);
        end
        n_tests++;
        if (got_words.size() == NWORDS && (got_words[50] !== 32'hE800_0000 || got_words[102] !== 32'hFFFF_FFFF)) begin
            n_fail++; $display("FAIL zero_sample: got %h/%h expected e8000000/ffffffff", got_words[50], got_words[102]);
        end
        n_tests++;
        if (done_pulses != 1 || done_cyc + 1 != 304) begin
            n_fail++; $display("FAIL zero_timing: pulses=%0d frame_cycles=%0d expected 1/304", done_pulses, done_cyc + 1);
        end
        n_tests++;
        if (busy_fall != 304) begin
            n_fail++; $display("FAIL zero_busy_fall: got cycle %0d expected 304", busy_fall);
        end
        n_tests++;
        if (addr_errs() != 0 || sel_err != 0) begin
            n_fail++; $display("FAIL zero_addr: addr_errs=%0d sel_err=%0d expected 0/0", addr_errs(), sel_err);
        end
    endtask

    task automatic test_colour_map();
        int fb, ne;
        fill_board(0, 1'b1); fill_board(1, 1'b0);
        board[1][0] = 2'b01; board[1][1] = 2'b10; board[1][2] = 2'b11;
        build_model(1'b1);
        run_frame(1'b1, 100, 1'b0, 1000);
        n_tests++;
        if (got_words.size() < 4 || got_words[1] !== 32'hE8FF_0000 || got_words[2] !== 32'hE800_00FF
            || got_words[3] !== 32'hE800_FF00) begin
            n_fail++; $display("FAIL colour_map: got %0d words, w1..3 %h %h %h expected e8ff0000 e80000ff e800ff00",
                               got_words.size(), got_words[1], got_words[2], got_words[3]);
        end
        ne = word_errs(NWORDS, fb);
        n_tests++;
        if (ne != 0 || got_words.size() != NWORDS) begin
            n_fail++; $display("FAIL colour_frame: %0d bad words first %0d count %0d expected 0 bad count %0d",
                               ne, fb, got_words.size(), NWORDS);
        end
    endtask

    task automatic test_backpressure();
        int fb, ne;
        bit sel;
        for (int it = 0; it < 2; it++) begin
            fill_board(0, 1'b1); fill_board(1, 1'b1);
            sel = 1'($urandom_range(1));
            build_model(sel);
            run_frame(sel, 30, 1'b0, 6000);
            n_tests++;
            if (timed_out || stall_err != 0) begin
                n_fail++; $display("FAIL bp_stable: timeout=%0d unstable_cycles=%0d expected 0/0", timed_out, stall_err);
            end
            ne = word_errs(NWORDS, fb);
            n_tests++;
            if (ne != 0 || got_words.size() != NWORDS) begin
                n_fail++; $display("FAIL bp_words: %0d bad first %0d count %0d expected 0 bad count %0d",
                                   ne, fb, got_words.size(), NWORDS);
            end
            n_tests++;
            if (done_pulses != 1 || done_cyc + 1 != 304 + stall_cycles) begin
                n_fail++; $display("FAIL bp_timing: pulses=%0d frame_cycles=%0d expected 1/%0d",
                                   done_pulses, done_cyc + 1, 304 + stall_cycles);
            end
            n_tests++;
            if (sel_err != 0) begin
                n_fail++; $display("FAIL bp_sel_hold: sel_q wrong in %0d cycles expected 0", sel_err);
            end
        end
    endtask

    task automatic test_order();
        int bad = 0;
        int c;
        fill_board(0, 1'b1); fill_board(1, 1'b1);
        build_model(1'b0);
        run_frame(1'b0, 100, 1'b0, 1000);
        for (int k = 0; k < COLS; k++) begin
            c = SERP ? (COLS - 1 - k) : k;
            if (COLS + k >= got_addr.size() || got_addr[COLS + k] != 16 + c) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++; $display("FAIL order_row1: %0d wrong row-1 addresses expected 0 (serpentine=%0d)", bad, SERP);
        end
        n_tests++;
        if (addr_errs() != 0) begin
            n_fail++; $display("FAIL order_all: %0d address errors over %0d reads expected 0", addr_errs(), got_addr.size());
        end
    endtask

    task automatic test_back_to_back();
        run_frame(1'($urandom_range(1)), 100, 1'b1, 1000);
        n_tests++;
        if (timed_out || done_pulses != 1) begin
            n_fail++; $display("FAIL b2b_frame: timeout=%0d pulses=%0d expected 0/1", timed_out, done_pulses);
        end
        @(negedge ph2);
        @(negedge ph2);
        n_tests++;
        if (busy !== 1'b0 || bus.word_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_start_ignored: busy=%b valid=%b expected 0/0", busy, bus.word_valid);
        end
    endtask

    task automatic test_midframe();
        int k, fb, ne;
        int sel_errs = 0;
        int idle_errs = 0;
        int hold = 0;
        bit toggled = 1'b0;
        fill_board(0, 1'b1); fill_board(1, 1'b1);
        build_model(1'b0);
        got_words.delete();
        @(negedge ph2);
        start = 1'b1; board_sel = 1'b0; bus.word_ready = 1'b1;
        @(negedge ph2);
        start = 1'b0;
        for (k = 0; k < 2000; k++) begin
            if (bus.word_valid && bus.word_ready) got_words.push_back(bus.word);
            if (toggled) begin
                if (bus.sel_q !== 1'b0 || busy !== 1'b1) sel_errs++;
                if (hold > 0) hold--; else start = 1'b0;
            end
            if (!toggled && got_words.size() == 50) begin
                toggled = 1'b1; start = 1'b1; board_sel = 1'b1; hold = 3;
            end
            if (got_words.size() == 60) break;
            @(negedge ph2);
        end
        n_tests++;
        if (k >= 2000) begin n_fail++; $display("FAIL mid_reach60: only %0d words expected 60", got_words.size()); end
        n_tests++;
        if (sel_errs != 0) begin n_fail++; $display("FAIL mid_ignore_start: %0d bad cycles expected 0", sel_errs); end
        ne = word_errs(60, fb);
        n_tests++;
        if (ne != 0) begin n_fail++; $display("FAIL mid_prefix: %0d bad first %0d expected 0", ne, fb); end
        start = 1'b0; reset = 1'b0;
        @(negedge ph2);
        n_tests++;
        if (bus.word_valid !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0 || bus.rd_en !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: valid=%b busy=%b done=%b rd_en=%b expected 0/0/0/0",
                               bus.word_valid, busy, frame_done, bus.rd_en);
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge ph2);
            if (frame_done !== 1'b0 || busy !== 1'b0) idle_errs++;
        end
        n_tests++;
        if (idle_errs != 0) begin n_fail++; $display("FAIL mid_no_done: %0d bad idle cycles expected 0", idle_errs); end
        build_model(1'b1);
        run_frame(1'b1, 100, 1'b0, 1000);
        ne = word_errs(NWORDS, fb);
        n_tests++;
        if (timed_out || ne != 0 || got_words.size() != NWORDS || done_pulses != 1) begin
            n_fail++; $display("FAIL mid_restart: timeout=%0d bad=%0d count=%0d pulses=%0d expected 0/0/%0d/1",
                               timed_out, ne, got_words.size(), NWORDS, done_pulses);
        end
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; board_sel = 1'b0; bus.word_ready = 1'b1;
        test_reset();
        test_zero_board();
        test_colour_map();
        test_backpressure();
        test_order();
        test_back_to_back();
        test_midframe();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

endmodule

`default_nettype wire
